// File: rtl/sa_job_scheduler.sv
// sa_job_scheduler: arbitrates two job requesters, streams N*N operand pairs
// into a serially loaded systolic array, then writes back its result rows.
module sa_job_scheduler #(
  parameter int MATRIX_SIZE = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [1:0]                        req_valid,
  output logic [1:0]                        req_ready,
  input  logic [2*ADDR_WIDTH-1:0]           req_abase,
  input  logic [2*ADDR_WIDTH-1:0]           req_wbase,
  input  logic [2*ADDR_WIDTH-1:0]           req_rbase,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr_a,
  output logic [ADDR_WIDTH-1:0]             rd_addr_w,
  input  logic [DATA_WIDTH-1:0]             rd_data_a,
  input  logic [DATA_WIDTH-1:0]             rd_data_w,
  output logic                              sa_writing_signal,
  output logic signed [DATA_WIDTH-1:0]      sa_inputs,
  output logic signed [DATA_WIDTH-1:0]      sa_weights,
  input  logic                              sa_row_valid,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] sa_result_row,
  input  logic                              sa_finished,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] wr_data,
  output logic                              busy,
  output logic [1:0]                        done,
  output logic                              err
);
  localparam int N  = MATRIX_SIZE;
  localparam int KW = $clog2(N*N+1);
  localparam int RW = $clog2(N+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [KW-1:0] K_LAST = KW'(N*N-1);
  localparam logic [RW-1:0] N_ROWS = RW'(N);
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_WAIT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   abase_q, abase_d, wbase_q, wbase_d, rbase_q, rbase_d;
  logic [KW-1:0]           k_q, k_d;
  logic [RW-1:0]           row_q, row_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    err_q, err_d;
  logic                    wsig_q, wsig_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [N*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                    win;

  // Round-robin pick; ready is only offered in IDLE and never while reset is held.
  always_comb begin
    win = 1'b0;
    if (req_valid == 2'b11)      win = ~last_grant_q;
    else if (req_valid == 2'b10) win = 1'b1;
    req_ready = 2'b00;
    if (rstn && state_q == S_IDLE && req_valid != 2'b00)
      req_ready = win ? 2'b10 : 2'b01;
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    abase_d      = abase_q;
    wbase_d      = wbase_q;
    rbase_d      = rbase_q;
    k_d          = k_q;
    row_d        = row_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    wsig_d       = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_en        = 1'b0;
    done         = 2'b00;
    err          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_ready != 2'b00) begin
          grant_d = win;
          abase_d = win ? req_abase[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_abase[ADDR_WIDTH-1:0];
          wbase_d = win ? req_wbase[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_wbase[ADDR_WIDTH-1:0];
          rbase_d = win ? req_rbase[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_rbase[ADDR_WIDTH-1:0];
          k_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rd_en  = 1'b1;
        wsig_d = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_q == K_LAST) state_d = S_DRAIN;
      end
      // Last read's data reaches the array this cycle.
      S_DRAIN: begin
        row_d   = '0;
        tmo_d   = '0;
        err_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sa_row_valid && row_q < N_ROWS) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rbase_q + ADDR_WIDTH'(row_q);
          wr_data_d = sa_result_row;
          row_d     = row_q + 1'b1;
        end
        tmo_d = tmo_q + 1'b1;
        // A row arriving with sa_finished still counts toward completion.
        if (sa_finished) begin
          err_d   = (row_d != N_ROWS);
          state_d = S_DONE;
        end else if (tmo_d == TMO) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done         = grant_q ? 2'b10 : 2'b01;
        err          = err_q;
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      abase_q      <= '0;
      wbase_q      <= '0;
      rbase_q      <= '0;
      k_q          <= '0;
      row_q        <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      wsig_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      abase_q      <= abase_d;
      wbase_q      <= wbase_d;
      rbase_q      <= rbase_d;
      k_q          <= k_d;
      row_q        <= row_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      wsig_q       <= wsig_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign rd_addr_a         = abase_q + ADDR_WIDTH'(k_q);
  assign rd_addr_w         = wbase_q + ADDR_WIDTH'(k_q);
  assign sa_writing_signal = wsig_q;
  assign sa_inputs         = wsig_q ? rd_data_a : '0;
  assign sa_weights        = wsig_q ? rd_data_w : '0;
  assign wr_en             = wr_en_q;
  assign wr_addr           = wr_addr_q;
  assign wr_data           = wr_data_q;
  assign busy              = (state_q != S_IDLE);
endmodule
